om_access_checker: RTL and testbench
====================================

# om_access_checker

Downstream consumer of the object-metadata range buffer: it accepts load/store addresses from the LSU side, checks the first and last byte of each access against the stored object ranges through the buffer's lookup port, and returns an ok/fault verdict. Accesses outside a configured heap window bypass the lookup. It also holds the fault address, a sticky fault flag and a saturating fault counter for the exception and debug logic.

## Interface
- HEAP_BASE, 32'h8000_0000, first byte of the checked window (inclusive)
- HEAP_LIMIT, 32'h8FFF_FFFF, last byte of the checked window (inclusive)
- CNT_W, 16, fault counter width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  access request valid
- req_ready_o  out  1  checker can accept a request
- req_addr_i  in  32  access start byte address
- req_size_i  in  2  log2 access bytes (0=1B, 1=2B, 2=4B, 3 treated as 4B)
- find_addr_o  out  32  address presented to the range buffer
- find_o  out  1  lookup strobe
- addr_in_range_i  in  1  range-buffer hit, combinational on find_addr_o
- resp_valid_o  out  1  verdict valid
- resp_ready_i  in  1  verdict consumed
- resp_ok_o  out  1  1 = access allowed
- fault_addr_o  out  32  start address of the most recent faulting access
- fault_sticky_o  out  1  set on any fault, cleared by fault_clr_i
- fault_clr_i  in  1  clear sticky flag
- fault_cnt_o  out  CNT_W  saturating count of faults

## Operation
- FSM states: IDLE, LOOK_LO, LOOK_HI, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch addr; last = addr + (1<<size) - 1, 32-bit modulo.
- Bypass: if last < HEAP_BASE or addr > HEAP_LIMIT, or the last computation wrapped past 2^32, go directly to RESP with ok=1. A wrapped access is bypassed, not checked.
- Otherwise go to LOOK_LO: find_o=1, find_addr_o=addr, sample addr_in_range_i into hit_lo.
- LOOK_HI: find_o=1, find_addr_o=last, sample hit_hi. If size=0, LOOK_HI is still executed.
- RESP: resp_valid_o=1, resp_ok_o = hit_lo & hit_hi. Both bytes may hit different objects; this is accepted.
- RESP holds its outputs stable until resp_ready_i=1, then returns to IDLE.
- Fault is recorded on the RESP handshake with ok=0:
  - fault_addr_o <= addr
  - fault_sticky_o <= 1
  - fault_cnt_o increments, saturating at all-ones
- Sticky flag: if fault_clr_i and a fault handshake occur in the same cycle, set wins.
- Outside LOOK_*: find_o=0 and find_addr_o=0.

## Timing
- Reset values: all outputs 0 except req_ready_o=1. State=IDLE.
- Checked access: accepted at cycle T; LOOK_LO at T+1; LOOK_HI at T+2; resp_valid_o from T+3.
- Bypassed access: resp_valid_o from T+1.
- Throughput: no overlap between requests. The next request is accepted no earlier than the cycle after the response handshake.
- Range-buffer writes during LOOK_* are seen by whichever lookup samples after the write.
- Reset mid-operation: the in-flight access is dropped and no verdict is produced.

## Configuration
- OM_FAULT_COUNTER_EN:
  - Defined: fault_cnt_o is a CNT_W saturating counter as described.
  - Undefined: no counter register exists and fault_cnt_o is tied to 0.

## Structure
- om_pkg holds:
  - the FSM state typedef
  - the size-to-byte-count function
  - default HEAP_BASE/HEAP_LIMIT localparams
- Sub-module om_sat_counter (parameterised width, inc input, saturate) instantiates the fault counter. It is omitted when OM_FAULT_COUNTER_EN is undefined.

## Test plan
- Range buffer holds [0x8000_1000,0x8000_10FF]; word request at 0x8000_1000 -> find_addr 0x8000_1000 then 0x8000_1003, resp_ok=1 at T+3.
- Word request at 0x8000_10FE -> hi lookup 0x8000_1101 misses, resp_ok=0, fault_addr=0x8000_10FE, sticky=1, cnt=1.
- Request at 0x0000_0100 (outside window) -> no find_o pulse, resp_ok=1 at T+1.
- resp_ready_i held low 5 cycles during a fault -> outputs stable, cnt increments once; fault_clr_i in the same cycle as the handshake -> sticky remains 1.
- CNT_W=2 with 5 faults -> cnt saturates at 3. Without the macro -> cnt stays 0.
- rst_ni asserted during LOOK_HI -> next cycle IDLE, resp_valid_o=0, req_ready_o=1, all fault state cleared.

Source files
------------

// File: rtl/om_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : om_pkg                                                      |
// | Description : Shared types and helpers for the object-metadata access     |
// |               checker: FSM state encoding, access-size decoding and the   |
// |               default heap window bounds.                                 |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package om_pkg;

  // Checker FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOK_LO = 2'd1,
    LOOK_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Default checked heap window (both bounds inclusive).
  localparam logic [31:0] c_HEAP_BASE  = 32'h8000_0000;
  localparam logic [31:0] c_HEAP_LIMIT = 32'h8FFF_FFFF;

  // log2 access size to byte count; the encoding 3 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/om_access_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : om_access_checker_if                                        |
// | Description : Request/response handshake plus range-buffer lookup port    |
// |               of the access checker.                                      |
// |               slave  : the checker side                                   |
// |               master : the LSU / range-buffer side                        |
// |               Signals: req_valid_i/req_ready_o/req_addr_i/req_size_i,     |
// |               find_addr_o/find_o/addr_in_range_i,                         |
// |               resp_valid_o/resp_ready_i/resp_ok_o                         |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface om_access_checker_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [31:0] find_addr_o;
  logic        find_o;
  logic        addr_in_range_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        resp_ok_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_size_i, addr_in_range_i, resp_ready_i,
    output req_ready_o, find_addr_o, find_o, resp_valid_o, resp_ok_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_size_i, addr_in_range_i, resp_ready_i,
    input  req_ready_o, find_addr_o, find_o, resp_valid_o, resp_ok_o
  );
endinterface
`default_nettype wire

// File: rtl/om_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : om_sat_counter                                              |
// | Description : Up-counter that sticks at all-ones.                         |
// |               clk_i  : clock                                              |
// |               rst_ni : asynchronous active-low reset                      |
// |               inc_i  : increment request                                  |
// |               cnt_o  : current count                                      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module om_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             inc_i,
  output logic [WIDTH-1:0]      cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/om_access_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : om_access_checker                                           |
// | Description : Checks the first and last byte of each LSU access against   |
// |               the object-range buffer and returns an ok/fault verdict.    |
// |               Accesses outside [HEAP_BASE, HEAP_LIMIT] (or whose last     |
// |               byte wraps past 2^32) bypass the lookup and are allowed.    |
// |               Ports : clk_i, rst_ni, bus (om_access_checker_if.slave),    |
// |                       fault_addr_o, fault_sticky_o, fault_clr_i,          |
// |                       fault_cnt_o                                         |
// |               Macro : OM_FAULT_COUNTER_EN - instantiates the saturating   |
// |                       fault counter; otherwise fault_cnt_o is zero.       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module om_access_checker
  import om_pkg::*;
#(
  parameter logic [31:0] HEAP_BASE  = c_HEAP_BASE,
  parameter logic [31:0] HEAP_LIMIT = c_HEAP_LIMIT,
  parameter int unsigned CNT_W      = 16
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  om_access_checker_if.slave     bus,
  output logic [31:0]            fault_addr_o,
  output logic                   fault_sticky_o,
  input  wire logic              fault_clr_i,
  output logic [CNT_W-1:0]       fault_cnt_o
);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_last;
  logic        r_hit_lo;
  logic        r_req_ready;
  logic        r_find;
  logic [31:0] r_find_addr;
  logic        r_resp_valid;
  logic        r_resp_ok;
  logic [31:0] r_fault_addr;
  logic        r_fault_sticky;

  // Last byte computed 33 bits wide so the carry flags a wrap past 2^32.
  logic [32:0] w_sum;
  logic [31:0] w_last;
  logic        w_bypass;
  logic        w_fault_hs;

  assign w_sum      = {1'b0, bus.req_addr_i} + {30'd0, size_bytes(bus.req_size_i)} - 33'd1;
  assign w_last     = w_sum[31:0];
  assign w_bypass   = w_sum[32] | (w_last < HEAP_BASE) | (bus.req_addr_i > HEAP_LIMIT);
  assign w_fault_hs = (r_state == RESP) & bus.resp_ready_i & ~r_resp_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_last       <= '0;
      r_hit_lo     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_find       <= 1'b0;
      r_find_addr  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_ok    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_addr      <= bus.req_addr_i;
            r_last      <= w_last;
            r_req_ready <= 1'b0;
            if (w_bypass) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_ok    <= 1'b1;
            end else begin
              r_state     <= LOOK_LO;
              r_find      <= 1'b1;
              r_find_addr <= bus.req_addr_i;
            end
          end
        end
        LOOK_LO: begin
          r_hit_lo    <= bus.addr_in_range_i;
          r_find_addr <= r_last;
          r_state     <= LOOK_HI;
        end
        LOOK_HI: begin
          // The high-byte hit is folded straight into the verdict register.
          r_resp_ok    <= r_hit_lo & bus.addr_in_range_i;
          r_resp_valid <= 1'b1;
          r_find       <= 1'b0;
          r_find_addr  <= '0;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_resp_ok    <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Fault capture; a fault in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault_addr   <= '0;
      r_fault_sticky <= 1'b0;
    end else if (w_fault_hs) begin
      r_fault_addr   <= r_addr;
      r_fault_sticky <= 1'b1;
    end else if (fault_clr_i) begin
      r_fault_sticky <= 1'b0;
    end
  end

`ifdef OM_FAULT_COUNTER_EN
  om_sat_counter #(
    .WIDTH (CNT_W)
  ) u_fault_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_fault_hs),
    .cnt_o  (fault_cnt_o)
  );
`else
  assign fault_cnt_o = '0;
`endif

  assign bus.req_ready_o  = r_req_ready;
  assign bus.find_o       = r_find;
  assign bus.find_addr_o  = r_find_addr;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_ok_o    = r_resp_ok;
  assign fault_addr_o     = r_fault_addr;
  assign fault_sticky_o   = r_fault_sticky;

endmodule
`default_nettype wire

// File: tb/tb_om_access_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_om_access_checker                                        |
// | Description : Self-checking bench for om_access_checker with a range      |
// |               buffer holding [0x8000_1000, 0x8000_10FF] and CNT_W=2.      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_om_access_checker;

  localparam int unsigned CNT_W = 2;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    bit          bypass;
    logic [31:0] last;
    bit          ok;
  } vec_t;

  logic             clk;
  logic             rst_ni;
  logic             fault_clr;
  logic [31:0]      fault_addr;
  logic             fault_sticky;
  logic [CNT_W-1:0] fault_cnt;

  logic [31:0] rb_lo = 32'h8000_1000;
  logic [31:0] rb_hi = 32'h8000_10FF;

  int errors = 0;
  int checks = 0;

  // Bench-side model of the fault state.
  logic [31:0] exp_fault_addr = '0;
  bit          exp_sticky     = 1'b0;
  int          nfaults        = 0;

  vec_t vecs[11];

  om_access_checker_if bus ();

  // Range buffer: combinational hit on the presented address.
  assign bus.addr_in_range_i = (bus.find_addr_o >= rb_lo) && (bus.find_addr_o <= rb_hi);

  om_access_checker #(
    .HEAP_BASE  (32'h8000_0000),
    .HEAP_LIMIT (32'h8FFF_FFFF),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .bus            (bus),
    .fault_addr_o   (fault_addr),
    .fault_sticky_o (fault_sticky),
    .fault_clr_i    (fault_clr),
    .fault_cnt_o    (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt();
`ifdef OM_FAULT_COUNTER_EN
    return (nfaults > 3) ? 32'd3 : 32'(nfaults);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_fault_state(input string name);
    chk({name, "_faddr"}, fault_addr, exp_fault_addr);
    chk({name, "_sticky"}, 32'(fault_sticky), 32'(exp_sticky));
    chk({name, "_cnt"}, 32'(fault_cnt), exp_cnt());
  endtask

  // Issue a request and follow it to the first RESP cycle (ends #1 after an edge).
  task automatic start_access(input string name, input vec_t v);
    @(negedge clk);
    chk({name, "_rdy"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_size_i  = v.size;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    if (!v.bypass) begin
      chk({name, "_lo_find"}, 32'(bus.find_o), 32'd1);
      chk({name, "_lo_addr"}, bus.find_addr_o, v.addr);
      chk({name, "_lo_vld"}, 32'(bus.resp_valid_o), 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_hi_find"}, 32'(bus.find_o), 32'd1);
      chk({name, "_hi_addr"}, bus.find_addr_o, v.last);
      @(posedge clk);
      #1;
    end
    chk({name, "_vld"}, 32'(bus.resp_valid_o), 32'd1);
    chk({name, "_ok"}, 32'(bus.resp_ok_o), 32'(v.ok));
    chk({name, "_find"}, 32'(bus.find_o), 32'd0);
    chk({name, "_faddr_bus"}, bus.find_addr_o, 32'd0);
    chk({name, "_busy"}, 32'(bus.req_ready_o), 32'd0);
  endtask

  // Complete the RESP handshake, optionally with a simultaneous clear.
  task automatic finish_access(input string name, input vec_t v, input bit clr);
    bus.resp_ready_i = 1'b1;
    fault_clr        = clr;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    fault_clr        = 1'b0;
    if (!v.ok) begin
      exp_fault_addr = v.addr;
      exp_sticky     = 1'b1;
      nfaults++;
    end else if (clr) begin
      exp_sticky = 1'b0;
    end
    chk({name, "_done_vld"}, 32'(bus.resp_valid_o), 32'd0);
    chk({name, "_done_rdy"}, 32'(bus.req_ready_o), 32'd1);
    chk_fault_state(name);
  endtask

  initial begin
    vec_t hold_v;

    vecs[0]  = '{32'h8000_1000, 2'd2, 1'b0, 32'h8000_1003, 1'b1};
    vecs[1]  = '{32'h8000_10FE, 2'd2, 1'b0, 32'h8000_1101, 1'b0};
    vecs[2]  = '{32'h0000_0100, 2'd2, 1'b1, 32'h0000_0103, 1'b1};
    vecs[3]  = '{32'h8000_10FF, 2'd0, 1'b0, 32'h8000_10FF, 1'b1};
    vecs[4]  = '{32'h8000_0FFF, 2'd1, 1'b0, 32'h8000_1000, 1'b0};
    vecs[5]  = '{32'h7FFF_FFFE, 2'd2, 1'b0, 32'h8000_0001, 1'b0};
    vecs[6]  = '{32'h7FFF_FFFC, 2'd2, 1'b1, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'h9000_0000, 2'd0, 1'b1, 32'h9000_0000, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFE, 2'd2, 1'b1, 32'h0000_0001, 1'b1};
    vecs[9]  = '{32'h8FFF_FFFF, 2'd3, 1'b0, 32'h9000_0002, 1'b0};
    vecs[10] = '{32'h8000_1080, 2'd1, 1'b0, 32'h8000_1081, 1'b1};

    rst_ni           = 1'b0;
    fault_clr        = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_size_i   = '0;
    bus.resp_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.req_ready_o), 32'd1);
    chk("rst_vld", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_ok", 32'(bus.resp_ok_o), 32'd0);
    chk("rst_find", 32'(bus.find_o), 32'd0);
    chk("rst_find_addr", bus.find_addr_o, 32'd0);
    chk_fault_state("rst");
    @(negedge clk);
    rst_ni = 1'b1;

    // Fault held in RESP for 5 cycles, then handshake together with a clear.
    hold_v = vecs[1];
    start_access("hold", hold_v);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_vld", i), 32'(bus.resp_valid_o), 32'd1);
      chk($sformatf("hold%0d_ok", i), 32'(bus.resp_ok_o), 32'd0);
      chk_fault_state($sformatf("hold%0d", i));
    end
    finish_access("hold", hold_v, 1'b1);

    // A clear on its own drops the sticky flag.
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr  = 1'b0;
    exp_sticky = 1'b0;
    chk_fault_state("clr");

    for (int i = 0; i < 11; i++) begin
      start_access($sformatf("v%0d", i), vecs[i]);
      finish_access($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Reset asserted while in LOOK_HI drops the access.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = vecs[0].addr;
    bus.req_size_i  = vecs[0].size;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_hi_addr", bus.find_addr_o, vecs[0].last);
    rst_ni = 1'b0;
    #1;
    exp_fault_addr = '0;
    exp_sticky     = 1'b0;
    nfaults        = 0;
    chk("mid_vld", 32'(bus.resp_valid_o), 32'd0);
    chk("mid_rdy", 32'(bus.req_ready_o), 32'd1);
    chk("mid_find", 32'(bus.find_o), 32'd0);
    chk_fault_state("mid");
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_vld", i), 32'(bus.resp_valid_o), 32'd0);
    end
    start_access("post", vecs[0]);
    finish_access("post", vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
